// File: rtl/req_apb_bridge_pkg.sv
// Shared APB definitions: bus widths, wait-timer width and bridge state encoding.
package req_apb_bridge_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int APB_PROT_W = 3;
  localparam int TIMER_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/req_apb_bridge_wait_timer.sv
// Saturating count of PREADY-low ACCESS cycles; flags the last tolerated cycle.
module apb_wait_timer
  import req_apb_bridge_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit            TIMER_ON = (TIMEOUT != 0);
  localparam logic [31:0]   LIMIT    = TIMER_ON ? 32'(TIMEOUT - 1) : 32'd0;

  logic [TIMER_W-1:0] count;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // A TIMEOUT larger than the counter range can never match, so it behaves as disabled.
  assign expired = TIMER_ON && ({{(32 - TIMER_W){1'b0}}, count} == LIMIT);

endmodule

// File: rtl/req_apb_bridge.sv
// Single-outstanding request/response to APB4 master bridge with optional PREADY timeout.
module req_apb_bridge
  import req_apb_bridge_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [APB_ADDR_W-1:0] REQ_ADDR,
  input  logic                  REQ_WRITE,
  input  logic [APB_DATA_W-1:0] REQ_WDATA,
  input  logic [APB_STRB_W-1:0] REQ_STRB,
  input  logic [APB_PROT_W-1:0] REQ_PROT,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [APB_DATA_W-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_STRB_W-1:0] PSTRB,
  output logic [APB_PROT_W-1:0] PPROT,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [APB_DATA_W-1:0] PRDATA
);

  bridge_state_e state;
  logic          timer_clear;
  logic          timer_enable;
  logic          timer_expired;

  assign REQ_READY    = (state == ST_IDLE);
  assign timer_clear  = (state == ST_SETUP);
  assign timer_enable = (state == ST_ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            PADDR   <= REQ_ADDR;
            PWRITE  <= REQ_WRITE;
            PWDATA  <= REQ_WDATA;
            PSTRB   <= REQ_WRITE ? REQ_STRB : '0;
            PPROT   <= REQ_PROT;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        // A completing PREADY takes priority over a timeout firing on the same cycle.
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            RSP_ERR   <= PSLVERR;
            RSP_RDATA <= PWRITE ? '0 : PRDATA;
            RSP_VALID <= 1'b1;
            state     <= ST_RESP;
          end else if (timer_expired) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            RSP_ERR   <= 1'b1;
            RSP_RDATA <= '0;
            RSP_VALID <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
